// File: rtl/serial_fb_loader_tx_if.sv
// -----------------------------------------------------------------------------
// serial_fb_loader_tx_if
//   Byte stream into the framebuffer load-link transmitter.
//
//   Handshake: a byte transfers on a rising clk edge where in_valid and
//   in_ready are both high. The source holds in_data stable while in_valid is
//   high and must not wait for in_ready before raising in_valid. The sink may
//   raise or drop in_ready on its own.
//
//   Signals:
//     in_data  [7:0]  byte to send (source -> sink)
//     in_valid        in_data is valid (source -> sink)
//     in_ready        sink accepts the byte this cycle (sink -> source)
//
//   Modports:
//     master - byte source (host side)
//     slave  - the transmitter
// -----------------------------------------------------------------------------
interface serial_fb_loader_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/serial_fb_loader_tx.sv
// -----------------------------------------------------------------------------
// serial_fb_loader_tx
//   Host-side transmitter for the two-wire framebuffer load link
//   (ser_clk / ser_data) feeding the VGA BRAM display. Each accepted byte is
//   shifted out MSB first, one bit per ser_clk transition (rising and falling
//   both count). At frame start the target is held in reset so its write
//   address restarts at 0. Bit and byte pacing leave room for a receiver that
//   samples through a 3-flop synchroniser and needs 6 cycles per BRAM write.
//
//   Parameters:
//     BIT_DIV     clk cycles per half bit (setup phase, hold phase), >= 4
//     BYTE_GAP    idle cycles after the last edge of a byte, >= 6
//     FRAME_BYTES bytes per frame, 1..65535
//     RST_CYCLES  cycles tgt_rst is held high at frame start, >= 1
//
//   Ports:
//     clk          clock
//     reset        synchronous, active-high
//     start        one-cycle frame request (honoured only when idle)
//     in_if        byte stream (slave modport: in_data, in_valid, in_ready)
//     ser_clk      link clock, one bit per transition
//     ser_data     link data
//     tgt_rst      receiver reset
//     busy         high from start acceptance until the frame completes
//     frame_done   one-cycle pulse at frame end
//     byte_cnt     bytes fully sent in the current frame
//     frame_cksum  mod-256 sum of the frame's bytes (0 unless SERTX_CKSUM_EN)
//     dbg_state    current FSM state
//
//   Build option:
//     SERTX_CKSUM_EN  when defined, frame_cksum accumulates accepted bytes;
//                     otherwise it is tied to 0 and no adder exists.
// -----------------------------------------------------------------------------
module serial_fb_loader_tx #(
    parameter int BIT_DIV     = 8,
    parameter int BYTE_GAP    = 16,
    parameter int FRAME_BYTES = 8192,
    parameter int RST_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    serial_fb_loader_tx_if.slave  in_if,
    output logic                  ser_clk,
    output logic                  ser_data,
    output logic                  tgt_rst,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           byte_cnt,
    output logic [7:0]            frame_cksum,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RST   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] SETUP = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    // Terminal values of the shared phase counter.
    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] GAP_LAST = 32'(BYTE_GAP - 1);
    localparam logic [31:0] DIV_LAST = 32'(BIT_DIV - 1);
    localparam logic [15:0] FRAME_N  = 16'(FRAME_BYTES);

    logic [2:0]  state;
    logic [31:0] cnt;
    logic [2:0]  bit_idx;
    // Only the bits still to send; bit 7 leaves for ser_data at capture.
    logic [6:0]  shreg;

    logic handshake;
    logic start_ok;

    assign handshake = (state == LOAD) && in_if.in_valid && in_if.in_ready;
    assign start_ok  = (state == IDLE) && start;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            ser_clk        <= 1'b0;
            ser_data       <= 1'b0;
            tgt_rst        <= 1'b0;
            in_if.in_ready <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            byte_cnt       <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state    <= RST;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        tgt_rst  <= 1'b1;
                        byte_cnt <= '0;
                        ser_clk  <= 1'b0;
                        ser_data <= 1'b0;
                    end
                end

                RST: begin
                    ser_clk  <= 1'b0;
                    ser_data <= 1'b0;
                    if (cnt == RST_LAST) begin
                        tgt_rst <= 1'b0;
                        cnt     <= '0;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                // Also serves as the quiet period after the target reset.
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt            <= '0;
                        in_if.in_ready <= 1'b1;
                        state          <= LOAD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                LOAD: begin
                    if (handshake) begin
                        shreg          <= in_if.in_data[6:0];
                        ser_data       <= in_if.in_data[7];
                        bit_idx        <= '0;
                        cnt            <= '0;
                        in_if.in_ready <= 1'b0;
                        state          <= SETUP;
                    end
                end

                // Data was set on entry; the edge comes after BIT_DIV cycles.
                SETUP: begin
                    if (cnt == DIV_LAST) begin
                        ser_clk <= ~ser_clk;
                        cnt     <= '0;
                        state   <= HOLD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                // Data held BIT_DIV cycles past the edge before it may change.
                HOLD: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (bit_idx != 3'd7) begin
                            bit_idx  <= bit_idx + 3'd1;
                            ser_data <= shreg[6];
                            shreg    <= {shreg[5:0], 1'b0};
                            state    <= SETUP;
                        end else begin
                            byte_cnt <= byte_cnt + 16'd1;
                            if (byte_cnt + 16'd1 == FRAME_N) begin
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SERTX_CKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cksum <= '0;
        end else if (start_ok) begin
            frame_cksum <= '0;
        end else if (handshake) begin
            frame_cksum <= frame_cksum + in_if.in_data;
        end
    end
`else
    assign frame_cksum = 8'd0;
`endif

endmodule

// File: doc/serial_fb_loader_tx.md
Name: serial_fb_loader_tx

Overview:
- Host-side transmitter for the two-wire framebuffer load link (serial_clk / serial_data) used by the VGA BRAM display.
- Accepts a stream of bytes over valid/ready and shifts each byte out MSB first, one bit per serial_clk edge (both rising and falling edges count as bit strobes).
- Pulses the target's reset at frame start so the receiver's write address restarts at 0.
- Paces bits and bytes so a receiver that samples with a 3-flop synchroniser and spends 6 cycles per BRAM write never misses data.

Parameters:
- BIT_DIV, 8: clk cycles per half bit. The data-setup phase and the hold-after-edge phase each last BIT_DIV cycles. Legal range is 4 or more.
- BYTE_GAP, 16: idle clk cycles after the 8th edge of a byte, before the next byte is accepted. Legal range is 6 or more.
- FRAME_BYTES, 8192: bytes per frame. Range 1 to 65535.
- RST_CYCLES, 16: clk cycles that tgt_rst is held high at frame start. Range 1 or more.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- start, in, 1: one-cycle request to begin a frame.
- in_data, in, 8: byte to send.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: byte accepted when in_valid and in_ready are both high.
- ser_clk, out, 1: link clock. Each transition is one bit.
- ser_data, out, 1: link data.
- tgt_rst, out, 1: drives the receiver's reset input.
- busy, out, 1: high from start acceptance until the frame completes.
- frame_done, out, 1: one-cycle pulse at frame end.
- byte_cnt, out, 16: number of bytes fully sent in the current frame.
- frame_cksum, out, 8: see Optional Feature.

Behaviour:
- Reset values: state IDLE; ser_clk=0, ser_data=0, tgt_rst=0, in_ready=0, busy=0, frame_done=0, byte_cnt=0, frame_cksum=0. All outputs are registered.
- IDLE: start=1 moves to RST on the next cycle, clears byte_cnt and the checksum, and sets busy=1.
- start is ignored in every state except IDLE. There is no restart mid-frame.
- RST:
  - tgt_rst=1 for exactly RST_CYCLES cycles; ser_clk and ser_data are forced to 0.
  - Then tgt_rst=0, followed by BYTE_GAP cycles of quiet, then LOAD.
- LOAD:
  - in_ready=1 in this state only.
  - On a handshake: capture in_data into the shift register, drive ser_data=in_data[7] on the same clock edge, set bit_idx=0, go to SETUP.
- SETUP: hold ser_clk and ser_data for BIT_DIV cycles, then toggle ser_clk and go to HOLD.
- HOLD: hold for BIT_DIV cycles, then:
  - If bit_idx<7: bit_idx+1, ser_data = the next lower bit (MSB first), go to SETUP.
  - If bit_idx==7: byte_cnt+1. If the new byte_cnt equals FRAME_BYTES, go to DONE; otherwise go to GAP.
- ser_data changes only at the SETUP entry. It is never changed in the same cycle as a ser_clk toggle.
- Exactly 8 ser_clk toggles per byte, so ser_clk is 0 again at every byte boundary.
- GAP: BYTE_GAP cycles, then LOAD.
- DONE: frame_done=1 for one cycle, busy=0, then IDLE. byte_cnt and frame_cksum hold their values until the next start.
- Byte period: 1 LOAD cycle (minimum, more while in_valid=0) + 16*BIT_DIV + BYTE_GAP cycles. Defaults give 145 cycles.
- in_valid low in LOAD: wait indefinitely. ser_clk and ser_data stay static; no timeout.
- reset mid-frame: everything returns to reset values on the next cycle. tgt_rst is not asserted by this reset. Any partial byte is discarded by the next frame's tgt_rst pulse.
- Counter widths: byte_cnt is 16 bits. The FRAME_BYTES compare is exact; no wrap within a frame.

Optional Feature:
- Macro: SERTX_CKSUM_EN.
- Defined: frame_cksum holds the mod-256 sum of all bytes accepted in the current frame. It updates on each LOAD handshake, is cleared at start acceptance, and is held after DONE.
- Undefined: frame_cksum is constant 0 and no adder is built.

Test Plan:
- FRAME_BYTES=1, BIT_DIV=4, byte 0xA5 -> tgt_rst high 16 cycles; 8 ser_clk toggles spaced 8 cycles apart; ser_data 1,0,1,0,0,1,0,1 stable 4 cycles either side of each toggle; frame_done pulse; byte_cnt=1.
- FRAME_BYTES=4, bytes 0x01,0x02,0x80,0xFF fed through a behavioural model of the 3-flop receiver at the same clk -> receiver reconstructs 01,02,80,FF at addresses 0..3; byte-to-byte spacing is 16*BIT_DIV+BYTE_GAP+1 cycles.
- in_valid held low 50 cycles in LOAD -> in_ready=1 throughout, no ser_clk activity, transmission resumes on the first valid cycle.
- start pulsed mid-frame -> ignored; byte_cnt continues, only one frame_done.
- reset asserted during bit 3 of byte 2 -> next cycle ser_clk=0, busy=0, byte_cnt=0; a following start sends the full frame correctly.
- SERTX_CKSUM_EN defined, bytes 0x80,0x90,0x10 -> frame_cksum=0x20. Undefined -> frame_cksum=0.
